id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_if.sv | 33 +++
 rtl/id_ex_stage.sv | 103 ++++++++++
 tb/tb_id_ex_stage.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/id_ex_if.sv
// Decode-to-execute bundle: decode-stage fields, EX pipeline register contents
// and the hazard/stall side signals exchanged with the pipeline control.
interface id_ex_if;
  logic        id_valid, id_regwrite, id_memread, id_memwrite;
  logic [3:0]  id_rs, id_rt, id_rd, id_opcode;
  logic        id_rs_used, id_rt_used;
  logic [15:0] id_rs_data, id_rt_data, id_imm, id_pc;
  logic        flush, mem_stall;

  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite;
  logic [3:0]  ex_rs, ex_rt, ex_rd, ex_opcode;
  logic [15:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc;
  logic        stall_if_id;
  logic [7:0]  hazard_count;

  modport master (
    output id_valid, id_regwrite, id_memread, id_memwrite,
           id_rs, id_rt, id_rd, id_opcode, id_rs_used, id_rt_used,
           id_rs_data, id_rt_data, id_imm, id_pc, flush, mem_stall,
    input  ex_valid, ex_regwrite, ex_memread, ex_memwrite,
           ex_rs, ex_rt, ex_rd, ex_opcode,
           ex_rs_data, ex_rt_data, ex_imm, ex_pc, stall_if_id, hazard_count
  );

  modport slave (
    input  id_valid, id_regwrite, id_memread, id_memwrite,
           id_rs, id_rt, id_rd, id_opcode, id_rs_used, id_rt_used,
           id_rs_data, id_rt_data, id_imm, id_pc, flush, mem_stall,
    output ex_valid, ex_regwrite, ex_memread, ex_memwrite,
           ex_rs, ex_rt, ex_rd, ex_opcode,
           ex_rs_data, ex_rt_data, ex_imm, ex_pc, stall_if_id, hazard_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold control
// and a saturating count of inserted load-use bubbles.
//   state  | meaning
//   RUN    | normal operation, load-use detection active
//   BUBBLE | EX holds the bubble just inserted; ID instruction captured next
module id_ex_stage (
  input  logic     clk,
  input  logic     rst,
  id_ex_if.slave   bus
);

  typedef enum logic {RUN = 1'b0, BUBBLE = 1'b1} state_t;

  state_t state, state_nxt;
  logic   dep_rs, dep_rt_alu, load_use;
  logic   load_bubble, capture, hz_inc, stall;

  assign dep_rs     = bus.id_rs_used & (bus.id_rs == bus.ex_rd);
  // Store data reaches MEM through MEM-to-MEM forwarding, so SW rt never stalls.
  assign dep_rt_alu = bus.id_rt_used & (bus.id_rt == bus.ex_rd) & ~bus.id_memwrite;
  assign load_use   = bus.ex_valid & bus.ex_memread & (bus.ex_rd != 4'd0) &
                      bus.id_valid & (dep_rs | dep_rt_alu);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    load_bubble = 1'b0;
    capture     = 1'b0;
    hz_inc      = 1'b0;
    stall       = 1'b0;
    if (bus.flush) begin
      load_bubble = 1'b1;
      state_nxt   = RUN;
    end else if (bus.mem_stall) begin
      stall = 1'b1;
    end else if (state == RUN && load_use) begin
      load_bubble = 1'b1;
      stall       = 1'b1;
      hz_inc      = 1'b1;
      state_nxt   = BUBBLE;
    end else begin
      capture   = 1'b1;
      state_nxt = RUN;
    end
  end

  assign bus.stall_if_id = stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ex_valid    <= 1'b0;
      bus.ex_regwrite <= 1'b0;
      bus.ex_memread  <= 1'b0;
      bus.ex_memwrite <= 1'b0;
      bus.ex_rs       <= 4'd0;
      bus.ex_rt       <= 4'd0;
      bus.ex_rd       <= 4'd0;
      bus.ex_opcode   <= 4'd0;
      bus.ex_rs_data  <= 16'd0;
      bus.ex_rt_data  <= 16'd0;
      bus.ex_imm      <= 16'd0;
      bus.ex_pc       <= 16'd0;
    end else if (load_bubble || (capture && !bus.id_valid)) begin
      bus.ex_valid    <= 1'b0;
      bus.ex_regwrite <= 1'b0;
      bus.ex_memread  <= 1'b0;
      bus.ex_memwrite <= 1'b0;
      bus.ex_rs       <= 4'd0;
      bus.ex_rt       <= 4'd0;
      bus.ex_rd       <= 4'd0;
      bus.ex_opcode   <= 4'd0;
      bus.ex_rs_data  <= 16'd0;
      bus.ex_rt_data  <= 16'd0;
      bus.ex_imm      <= 16'd0;
      bus.ex_pc       <= 16'd0;
    end else if (capture) begin
      bus.ex_valid    <= bus.id_valid;
      bus.ex_regwrite <= bus.id_regwrite;
      bus.ex_memread  <= bus.id_memread;
      bus.ex_memwrite <= bus.id_memwrite;
      bus.ex_rs       <= bus.id_rs;
      bus.ex_rt       <= bus.id_rt;
      bus.ex_rd       <= bus.id_rd;
      bus.ex_opcode   <= bus.id_opcode;
      bus.ex_rs_data  <= bus.id_rs_data;
      bus.ex_rt_data  <= bus.id_rt_data;
      bus.ex_imm      <= bus.id_imm;
      bus.ex_pc       <= bus.id_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bus.hazard_count <= 8'd0;
    else if (hz_inc && bus.hazard_count != 8'hFF)
      bus.hazard_count <= bus.hazard_count + 8'd1;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard scenarios plus random
// traffic compared against a transaction-level model of the stage.
module tb_id_ex_stage;

  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_if bus ();
  id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        valid, regwrite, memread, memwrite;
    logic [3:0]  rs, rt, rd, opcode;
    logic [15:0] rs_data, rt_data, imm, pc;
  } ex_t;

  ex_t m_ex;
  bit  m_bub;
  int  m_cnt;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ex_t dut_ex();
    ex_t e;
    e = {bus.ex_valid, bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite,
         bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_opcode,
         bus.ex_rs_data, bus.ex_rt_data, bus.ex_imm, bus.ex_pc};
    return e;
  endfunction

  function automatic ex_t id_as_ex();
    ex_t e;
    e = '0;
    if (bus.id_valid)
      e = {bus.id_valid, bus.id_regwrite, bus.id_memread, bus.id_memwrite,
           bus.id_rs, bus.id_rt, bus.id_rd, bus.id_opcode,
           bus.id_rs_data, bus.id_rt_data, bus.id_imm, bus.id_pc};
    return e;
  endfunction

  task automatic set_id(input logic v, input logic rw, input logic mr, input logic mw,
                        input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd,
                        input logic [3:0] op, input logic rsu, input logic rtu,
                        input logic [15:0] pc);
    bus.id_valid    = v;   bus.id_regwrite = rw;
    bus.id_memread  = mr;  bus.id_memwrite = mw;
    bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd; bus.id_opcode = op;
    bus.id_rs_used = rsu;  bus.id_rt_used = rtu;
    bus.id_rs_data = 16'($urandom); bus.id_rt_data = 16'($urandom);
    bus.id_imm     = 16'($urandom); bus.id_pc      = pc;
  endtask

  // One clock: check the combinational stall against the model, advance the
  // model by the stage's rules, then check the registered state after the edge.
  task automatic cycle();
    bit   lu;
    logic exp_stall;
    lu = m_ex.valid && m_ex.memread && (m_ex.rd != 4'd0) && bus.id_valid &&
         ((bus.id_rs_used && bus.id_rs == m_ex.rd) ||
          (bus.id_rt_used && bus.id_rt == m_ex.rd && !bus.id_memwrite));
    lu = lu && !m_bub;
    exp_stall = !bus.flush && (bus.mem_stall || lu);
    #1;
    chk("stall_if_id", 128'(bus.stall_if_id), 128'(exp_stall));
    if (bus.flush) begin
      m_ex = '0; m_bub = 0;
    end else if (bus.mem_stall) begin
      // hold everything
    end else if (lu) begin
      m_ex = '0; m_bub = 1;
      if (m_cnt < 255) m_cnt++;
    end else begin
      m_ex = id_as_ex(); m_bub = 0;
    end
    @(posedge clk);
    #1;
    chk("ex_bundle", 128'(dut_ex()), 128'(m_ex));
    chk("hazard_count", 128'(bus.hazard_count), 128'(m_cnt[7:0]));
  endtask

  // Asynchronous reset asserted between edges; effect must be visible at once.
  task automatic pulse_reset();
    bus.flush = 1'b0; bus.mem_stall = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_hazard_count", 128'(bus.hazard_count), 128'd0);
    chk("rst_ex_valid", 128'(bus.ex_valid), 128'd0);
    chk("rst_ex_bundle", 128'(dut_ex()), 128'd0);
    chk("rst_stall", 128'(bus.stall_if_id), 128'd0);
    m_ex = '0; m_bub = 0; m_cnt = 0;
    #1 rst = 1'b0;
  endtask

  initial begin
    m_ex = '0; m_bub = 0; m_cnt = 0;
    rst = 1'b1;
    bus.flush = 1'b0; bus.mem_stall = 1'b0;
    set_id(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 16'd0);
    #12;
    chk("reset_ex_bundle", 128'(dut_ex()), 128'd0);
    chk("reset_hazard_count", 128'(bus.hazard_count), 128'd0);
    @(negedge clk) rst = 1'b0;

    // Load-use on rs
    set_id(1, 1, 1, 0, 4'd1, 4'd0, 4'd3, OP_LW, 1, 0, 16'h0010); cycle();
    set_id(1, 1, 0, 0, 4'd3, 4'd4, 4'd6, OP_ADD, 1, 1, 16'h0012);
    #1 chk("lu_stall", 128'(bus.stall_if_id), 128'd1);
    cycle();
    chk("lu_bubble_valid", 128'(bus.ex_valid), 128'd0);
    chk("lu_hazard_count", 128'(bus.hazard_count), 128'd1);
    cycle();
    chk("lu_ex_opcode", 128'(bus.ex_opcode), 128'(OP_ADD));
    chk("lu_ex_rs", 128'(bus.ex_rs), 128'd3);

    // Store-data exemption
    set_id(1, 1, 1, 0, 4'd1, 4'd0, 4'd5, OP_LW, 1, 0, 16'h0020); cycle();
    set_id(1, 0, 0, 1, 4'd2, 4'd5, 4'd0, OP_SW, 1, 1, 16'h0022);
    #1 chk("sw_no_stall", 128'(bus.stall_if_id), 128'd0);
    cycle();
    chk("sw_captured", 128'(bus.ex_opcode), 128'(OP_SW));
    chk("sw_hazard_count", 128'(bus.hazard_count), 128'd1);

    // Zero register destination
    set_id(1, 1, 1, 0, 4'd1, 4'd0, 4'd0, OP_LW, 1, 0, 16'h0030); cycle();
    set_id(1, 1, 0, 0, 4'd0, 4'd1, 4'd2, OP_ADD, 1, 0, 16'h0032); cycle();
    chk("r0_captured", 128'(bus.ex_pc), 128'h0032);

    // Flush beats mem_stall and load-use
    set_id(1, 1, 1, 0, 4'd1, 4'd0, 4'd3, OP_LW, 1, 0, 16'h0038); cycle();
    set_id(1, 1, 0, 0, 4'd3, 4'd0, 4'd6, OP_ADD, 1, 0, 16'h003A);
    bus.flush = 1'b1; bus.mem_stall = 1'b1;
    #1 chk("flush_stall", 128'(bus.stall_if_id), 128'd0);
    cycle();
    chk("flush_bubble", 128'(dut_ex()), 128'd0);
    chk("flush_hazard_count", 128'(bus.hazard_count), 128'd1);
    bus.flush = 1'b0; bus.mem_stall = 1'b0;

    // mem_stall hold
    set_id(1, 1, 0, 0, 4'd1, 4'd2, 4'd3, OP_ADD, 1, 1, 16'h0040); cycle();
    bus.mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 1, 0, 0, 4'd1, 4'd2, 4'd3, OP_ADD, 1, 1, 16'h0044 + 16'(i));
      #1 chk("hold_stall", 128'(bus.stall_if_id), 128'd1);
      cycle();
      chk("hold_ex_pc", 128'(bus.ex_pc), 128'h0040);
    end
    bus.mem_stall = 1'b0;

    // Reset while holding a bubble under mem_stall, then normal capture
    set_id(1, 1, 1, 0, 4'd1, 4'd0, 4'd7, OP_LW, 1, 0, 16'h0050); cycle();
    set_id(1, 1, 0, 0, 4'd7, 4'd0, 4'd2, OP_ADD, 1, 0, 16'h0052); cycle();
    bus.mem_stall = 1'b1; cycle();
    pulse_reset();
    set_id(1, 1, 0, 0, 4'd7, 4'd0, 4'd2, OP_ADD, 1, 0, 16'h0054); cycle();
    chk("post_rst_capture", 128'(bus.ex_pc), 128'h0054);

    // Saturation: back-to-back dependent loads
    set_id(1, 1, 1, 0, 4'd1, 4'd0, 4'd1, OP_LW, 1, 0, 16'h0060);
    for (int i = 0; i < 530; i++) cycle();
    chk("sat_hazard_count", 128'(bus.hazard_count), 128'd255);
    pulse_reset();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      set_id(logic'($urandom_range(0, 7) != 0), logic'($urandom_range(0, 1)),
             logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) == 0),
             4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
             4'($urandom_range(0, 15)), logic'($urandom_range(0, 1)),
             logic'($urandom_range(0, 1)), 16'($urandom));
      bus.flush     = ($urandom_range(0, 7) == 0);
      bus.mem_stall = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 199) == 0) pulse_reset();
      else cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
